// File: rtl/rvj1_mem_pkg.sv
// Shared definitions for the rvj1 data RAM port: default geometry, WB base
// address and the WB responder state encoding.
`timescale 1ns/1ps
package rvj1_mem_pkg;

  localparam int unsigned RAM_AW_DEFAULT       = 10;
  localparam logic [31:0] BASE_ADDR_DEFAULT    = 32'h3000_0000;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_ram_arbiter.sv
// Core/WB arbitration for the shared data SRAM. The core has priority until a
// pending WB request has lost STARVE_LIMIT consecutive cycles.
`timescale 1ns/1ps
module wb_ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic arb_en_i,
  input  logic core_req_i,
  input  logic wb_req_i,
  output logic core_gnt_o,
  output logic wb_gnt_o
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 2);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          wb_wins;

  always_comb begin
    wb_wins      = wb_req_i && (!core_req_i || (starve_cnt_q == CW'(STARVE_LIMIT)));
    wb_gnt_o     = arb_en_i && wb_wins;
    core_gnt_o   = arb_en_i && core_req_i && !wb_wins;
    starve_cnt_d = '0;
    // Any cycle the WB request is absent or granted clears the count.
    if (arb_en_i && wb_req_i && !wb_wins) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/wb_data_ram_port.sv
// Wishbone-classic responder exposing the rvj1 data SRAM to the management SoC,
// sharing the single-port macro with the core data port.
//   state   | meaning
//   IDLE    | accepting WB requests; core may be granted
//   RD_WAIT | WB read issued to SRAM, capturing read data next edge
//   ACK     | wbs_ack_o high for this one cycle
`timescale 1ns/1ps
module wb_data_ram_port
  import rvj1_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT,
  parameter int unsigned RAM_AW       = RAM_AW_DEFAULT,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_be_i,
  input  logic [RAM_AW-1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  wb_state_e   state_q, state_d;
  logic        rdy_q;
  logic        block_q, block_d;
  logic        core_rvalid_q, core_rvalid_d;
  logic [31:0] wbs_dat_q, wbs_dat_d;

  logic [29:0] wb_word_off;
  logic        in_range;
  logic        idle;
  logic        wb_req;
  logic        wb_gnt;
  logic        core_gnt;
  logic        unused_adr_lsb;

  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  assign wb_word_off = wbs_adr_i[31:2] - BASE_ADDR[31:2];
  assign in_range    = (wb_word_off[29:RAM_AW] == '0);

  // rdy_q keeps the combinational grant low while reset is held.
  assign idle   = rdy_q && (state_q == IDLE);
  assign wb_req = wbs_cyc_i && wbs_stb_i && idle && !block_q;

  wb_ram_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .arb_en_i   (idle),
    .core_req_i (core_req_i),
    .wb_req_i   (wb_req && in_range),
    .core_gnt_o (core_gnt),
    .wb_gnt_o   (wb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    wbs_dat_d = wbs_dat_q;
    block_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_gnt) begin
          state_d = wbs_we_i ? ACK : RD_WAIT;
        end else if (wb_req && !in_range) begin
          state_d   = ACK;
          wbs_dat_d = '0;
        end
      end
      RD_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d   = ACK;
          wbs_dat_d = ram_rdata_i;
        end
      end
      ACK: begin
        state_d = IDLE;
        block_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (wb_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = wbs_we_i ? wbs_sel_i : 4'h0;
      ram_addr_o  = wb_word_off[RAM_AW-1:0];
      ram_wdata_o = wbs_dat_i;
    end else if (core_gnt) begin
      ram_en_o    = 1'b1;
      ram_we_o    = core_we_i ? core_be_i : 4'h0;
      ram_addr_o  = core_addr_i;
      ram_wdata_o = core_wdata_i;
    end
    core_rvalid_d = core_gnt && !core_we_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      rdy_q         <= 1'b0;
      block_q       <= 1'b0;
      core_rvalid_q <= 1'b0;
      wbs_dat_q     <= '0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= 1'b1;
      block_q       <= block_d;
      core_rvalid_q <= core_rvalid_d;
      wbs_dat_q     <= wbs_dat_d;
    end
  end

  assign wbs_ack_o     = (state_q == ACK);
  assign wbs_dat_o     = wbs_dat_q;
  assign core_gnt_o    = core_gnt;
  assign core_rvalid_o = core_rvalid_q;
  assign core_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_wb_data_ram_port.sv
// Bench for wb_data_ram_port: directed steps plus a randomized mix of WB and
// core accesses checked against a word-array model of the RAM contents.
`timescale 1ns/1ps
module tb_wb_data_ram_port;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 1024;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        core_req_i, core_we_i;
  logic [3:0]  core_be_i;
  logic [9:0]  core_addr_i;
  logic [31:0] core_wdata_i;
  logic        core_gnt_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  logic [31:0] sram    [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  int vectors = 0;
  int errors  = 0;

  wb_data_ram_port dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Single-port SRAM macro: byte writes, registered read data.
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) sram[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      if (ram_we_o == 4'h0) ram_rdata_i <= sram[ram_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit map_addr(input logic [31:0] adr, output int idx);
    logic [31:0] off;
    off = (adr - BASE) >> 2;
    idx = int'(off);
    return (adr >= BASE) && (off < DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  // Runs one WB access from a negedge; the master keeps stb high for one cycle
  // after ack, which must not start a second access.
  task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int exp_lat, output logic [31:0] rdat);
    int lat;
    bit got;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk_i);
      lat++;
      if (wbs_ack_o) got = 1;
    end
    check("wb_ack_seen", 32'(got), 32'd1);
    check("wb_ack_latency", lat, exp_lat);
    rdat = wbs_dat_o;
    @(negedge clk_i);
    check("wb_no_reissue_ram_en", 32'(ram_en_o), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge clk_i);
    check("wb_ack_one_pulse", 32'(wbs_ack_o), 32'd0);
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    int idx;
    wb_txn(1'b1, adr, dat, sel, 1, r);
    if (map_addr(adr, idx)) exp_mem[idx] = merge(exp_mem[idx], dat, sel);
  endtask

  task automatic wb_rd(input logic [31:0] adr);
    logic [31:0] r;
    int idx;
    bit hit;
    hit = map_addr(adr, idx);
    wb_txn(1'b0, adr, $urandom, 4'hF, hit ? 2 : 1, r);
    check("wb_rdata", r, hit ? exp_mem[idx] : 32'h0);
  endtask

  task automatic core_op(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
    core_req_i = 1'b1; core_we_i = we; core_addr_i = addr; core_wdata_i = wd; core_be_i = be;
    #1;
    check("core_gnt", 32'(core_gnt_o), 32'd1);
    check("core_ram_we", 32'(ram_we_o), we ? 32'(be) : 32'd0);
    @(negedge clk_i);
    core_req_i = 1'b0;
    check("core_rvalid", 32'(core_rvalid_o), we ? 32'd0 : 32'd1);
    if (!we) check("core_rdata", core_rdata_o, exp_mem[addr]);
    else exp_mem[addr] = merge(exp_mem[addr], wd, be);
  endtask

  initial begin
    logic [31:0] r, a, d;
    int idx;
    for (int i = 0; i < DEPTH; i++) begin sram[i] = '0; exp_mem[i] = '0; end
    ram_rdata_i = '0;
    rstn_i = 1'b0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    core_req_i = 1'b1; core_we_i = 0; core_be_i = 0; core_addr_i = 0; core_wdata_i = 0;

    repeat (2) @(negedge clk_i);
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_rvalid", 32'(core_rvalid_o), 32'd0);
    check("rst_gnt", 32'(core_gnt_o), 32'd0);
    check("rst_ram_en", 32'(ram_en_o), 32'd0);
    check("rst_ram_we", 32'(ram_we_o), 32'd0);
    core_req_i = 1'b0;
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);

    wb_wr(32'h3000_0010, 32'hCAFE_F00D, 4'hF);
    wb_rd(32'h3000_0010);

    wb_wr(32'h3000_0020, 32'h1111_1111, 4'hF);
    wb_wr(32'h3000_0020, 32'h00AB_0000, 4'b0100);
    wb_rd(32'h3000_0020);
    check("byte_merge_model", exp_mem[8], 32'h11AB_1111);

    wb_wr(32'h3000_0020, 32'hFFFF_FFFF, 4'h0);
    wb_rd(32'h3000_0020);

    // Out-of-range read alone: no RAM access, zero data.
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 4 * DEPTH; wbs_sel_i = 4'hF;
    #1 check("oor_ram_en", 32'(ram_en_o), 32'd0);
    @(negedge clk_i);
    check("oor_ack", 32'(wbs_ack_o), 32'd1);
    check("oor_dat", wbs_dat_o, 32'd0);
    check("oor_ack_ram_en", 32'(ram_en_o), 32'd0);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    repeat (2) @(negedge clk_i);

    // Out-of-range write alongside a core write: core proceeds the same cycle.
    d = $urandom;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = BASE - 4; wbs_dat_i = 32'hDEAD_BEEF;
    core_req_i = 1; core_we_i = 1; core_addr_i = 10'd9; core_wdata_i = d; core_be_i = 4'hF;
    #1;
    check("oor_core_gnt", 32'(core_gnt_o), 32'd1);
    check("oor_core_addr", 32'(ram_addr_o), 32'd9);
    exp_mem[9] = d;
    @(negedge clk_i);
    core_req_i = 0;
    check("oor_wr_ack", 32'(wbs_ack_o), 32'd1);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    repeat (2) @(negedge clk_i);
    wb_rd(BASE + 4 * 9);

    // Core held high against a pending WB read: four core grants, then WB.
    wb_wr(BASE + 4 * 7, 32'h7777_0007, 4'hF);
    core_req_i = 1; core_we_i = 0; core_addr_i = 10'd0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 4 * 7;
    for (int c = 0; c < 7; c++) begin
      #1;
      check("starve_core_gnt", 32'(core_gnt_o), (c < 4) ? 32'd1 : 32'd0);
      if (c == 4) check("starve_wb_addr", 32'(ram_addr_o), 32'd7);
      check("starve_ack", 32'(wbs_ack_o), (c == 6) ? 32'd1 : 32'd0);
      if (c == 6) begin
        check("starve_rdata", wbs_dat_o, 32'h7777_0007);
        wbs_cyc_i = 0; wbs_stb_i = 0;
      end
      @(negedge clk_i);
    end
    #1 check("starve_core_resume", 32'(core_gnt_o), 32'd1);
    @(negedge clk_i);
    core_req_i = 0;
    @(negedge clk_i);

    // Core read vs simultaneous WB read with no starvation: core wins.
    wb_wr(BASE + 4 * 5, 32'h0000_AB60, 4'hF);
    core_req_i = 1; core_we_i = 0; core_addr_i = 10'd5;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 4 * 12;
    #1 check("prio_core_gnt", 32'(core_gnt_o), 32'd1);
    @(negedge clk_i);
    core_req_i = 0;
    check("prio_rvalid", 32'(core_rvalid_o), 32'd1);
    check("prio_rdata", core_rdata_o, 32'h0000_AB60);
    #1 check("prio_wb_gnt_addr", 32'(ram_addr_o), 32'd12);
    repeat (2) @(negedge clk_i);
    check("prio_wb_ack", 32'(wbs_ack_o), 32'd1);
    check("prio_wb_dat", wbs_dat_o, exp_mem[12]);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    repeat (2) @(negedge clk_i);

    // cyc dropped while in RD_WAIT: no ack.
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 4 * 5;
    @(negedge clk_i);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge clk_i);
    check("abort_no_ack", 32'(wbs_ack_o), 32'd0);
    @(negedge clk_i);
    check("abort_no_ack_late", 32'(wbs_ack_o), 32'd0);
    wb_rd(BASE + 4 * 5);

    // Reset while in RD_WAIT.
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 4 * 4;
    @(negedge clk_i);
    core_req_i = 1;
    rstn_i = 0;
    #1;
    check("rst_mid_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_mid_gnt", 32'(core_gnt_o), 32'd0);
    check("rst_mid_ram_en", 32'(ram_en_o), 32'd0);
    @(negedge clk_i);
    check("rst_mid_ack_late", 32'(wbs_ack_o), 32'd0);
    wbs_cyc_i = 0; wbs_stb_i = 0; core_req_i = 0;
    rstn_i = 1;
    repeat (2) @(negedge clk_i);
    wb_rd(32'h3000_0010);

    // Reset drops a pending core rvalid.
    core_req_i = 1; core_we_i = 0; core_addr_i = 10'd4;
    @(negedge clk_i);
    core_req_i = 0;
    rstn_i = 0;
    #1 check("rst_rvalid_drop", 32'(core_rvalid_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 15);
      a = BASE + 4 * idx + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = BASE + 4 * (DEPTH + $urandom_range(0, 100));
      case ($urandom_range(0, 3))
        0: wb_wr(a, $urandom, 4'($urandom));
        1: wb_rd(a);
        2: core_op(1'b1, 10'(idx), $urandom, 4'($urandom));
        default: core_op(1'b0, 10'(idx), 32'h0, 4'h0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
